// File: rtl/sumador_pkg.sv
// Shared types and defaults for the bit-serial adder engine.
package sumador_pkg;

    localparam int unsigned SUMADOR_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ADD  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sumador_fa1b.sv
// Single-bit combinational full adder; the only arithmetic cell of the serial engine.
module sumador_fa1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sumador_serie.sv
// Bit-serial adder: WIDTH-bit a+b+cin computed LSB-first through one full adder.
// Optional signed-overflow output is enabled with `define SUMADOR_OVF_EN.
module sumador_serie
    import sumador_pkg::*;
#(
    parameter int unsigned WIDTH = SUMADOR_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             busy
`ifdef SUMADOR_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned     CW   = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0]   LAST = CW'(WIDTH - 1);

    state_t           state, state_nx;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] a_sh, b_sh, acc, acc_nx, sum_q;
    logic             carry, cout_q;
    logic             fa_s, fa_co;
    logic             accept, last;

    sumador_fa1b u_fa (
        .a  (a_sh[0]),
        .b  (b_sh[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        accept    = 1'b0;
        last      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    accept   = 1'b1;
                    state_nx = ADD;
                end
            end
            ADD: begin
                busy = 1'b1;
                if (count == LAST) begin
                    last     = 1'b1;
                    state_nx = DONE;
                end
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    // New sum bit enters at the MSB so bit i settles at position i after WIDTH shifts.
    always_comb begin
        acc_nx           = acc >> 1;
        acc_nx[WIDTH-1]  = fa_s;
    end

    // The shift accumulator is separate from sum_q so the visible result stays put during ADD.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sh   <= '0;
            b_sh   <= '0;
            acc    <= '0;
            sum_q  <= '0;
            carry  <= 1'b0;
            cout_q <= 1'b0;
            count  <= '0;
        end else if (accept) begin
            a_sh  <= a;
            b_sh  <= b;
            carry <= cin;
            count <= '0;
        end else if (state == ADD) begin
            a_sh  <= a_sh >> 1;
            b_sh  <= b_sh >> 1;
            acc   <= acc_nx;
            carry <= fa_co;
            if (last) begin
                sum_q  <= acc_nx;
                cout_q <= fa_co;
            end else begin
                count <= count + CW'(1);
            end
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

`ifdef SUMADOR_OVF_EN
    logic ovf_q;

    // In the final ADD cycle the carry FF holds the carry into the MSB stage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       ovf_q <= 1'b0;
        else if (state == ADD && last) ovf_q <= carry ^ fa_co;
    end

    assign ovf = ovf_q;
`endif

endmodule
